l1_cache_ctrl: RTL and testbench

L1_CACHE_CTRL -- requirements
Module: l1_cache_ctrl

---
 rtl/l1_pkg.sv | 27 ++
 rtl/l1_line_array.sv | 59 +++++
 rtl/l1_cache_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
// Shared types for the L1 cache controller:
// MSI line states, bus commands and controller FSM states.
package l1_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    M = 2'd2
  } msi_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPGRADE
  } state_t;

endpackage

// File: rtl/l1_line_array.sv
// Direct-mapped tag/state/data storage with one core
// read/write port and one snoop lookup/state-update port.
module l1_line_array
  import l1_pkg::*;
#(
  parameter int n     = 32,
  parameter int LINES = 16,
  parameter int IW    = $clog2(LINES),
  parameter int TW    = ADDR_W - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] c_idx,
  output logic [TW-1:0] c_tag,
  output msi_t          c_state,
  output logic [n-1:0]  c_data,
  input  logic          c_we,
  input  logic [TW-1:0] c_wtag,
  input  msi_t          c_wstate,
  input  logic [n-1:0]  c_wdata,
  input  logic [IW-1:0] s_idx,
  output logic [TW-1:0] s_tag,
  output msi_t          s_state,
  output logic [n-1:0]  s_data,
  input  logic          s_we,
  input  msi_t          s_wstate
);

  logic [TW-1:0] tags [LINES];
  msi_t          sts  [LINES];
  logic [n-1:0]  dats [LINES];

  assign c_tag   = tags[c_idx];
  assign c_state = sts[c_idx];
  assign c_data  = dats[c_idx];
  assign s_tag   = tags[s_idx];
  assign s_state = sts[s_idx];
  assign s_data  = dats[s_idx];

  // Core write is applied last: a fill replaces
  // whatever line a concurrent snoop matched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LINES; k++) begin
        tags[k] <= '0;
        sts[k]  <= I;
        dats[k] <= '0;
      end
    end else begin
      if (s_we) sts[s_idx] <= s_wstate;
      if (c_we) begin
        tags[c_idx] <= c_wtag;
        sts[c_idx]  <= c_wstate;
        dats[c_idx] <= c_wdata;
      end
    end
  end

endmodule

// File: rtl/l1_cache_ctrl.sv
// MSI snooping L1 controller: direct-mapped one-word lines,
// zero-latency hits, write-back/fetch/upgrade bus transactions.
module l1_cache_ctrl
  import l1_pkg::*;
#(
  parameter int n     = 32,
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_control,
  input  logic         store_control,
  input  logic [9:0]   address,
  input  logic [n-1:0] dmem_wdata,
  output logic [n-1:0] dmem_rdata,
  output logic         L1_busy,
  output logic         bus_req,
  output logic [1:0]   bus_cmd,
  output logic [9:0]   bus_addr,
  output logic [n-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [n-1:0] bus_rdata,
  input  logic         snoop_valid,
  input  logic [1:0]   snoop_cmd,
  input  logic [9:0]   snoop_addr,
  output logic         snoop_hit_m,
  output logic [n-1:0] snoop_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW;

  state_t        state, state_n;
  logic          req_q, req_n;
  bus_cmd_t      cmd_q, cmd_n;
  logic [9:0]    addr_q, addr_n;
  logic [n-1:0]  wd_q, wd_n;

  logic [IW-1:0] idx, s_idx;
  logic [TW-1:0] tag, s_tag_in;
  logic [TW-1:0] c_tag, c_wtag, s_tag;
  msi_t          c_state, c_wstate, s_state, s_wstate;
  logic [n-1:0]  c_data, c_wdata, s_data, rdata_c;
  logic          c_we, s_we, hit, s_match;
  logic          conflict, kill, busy_c, hit_m_c;
  bus_cmd_t      miss_cmd, scmd;

  assign idx      = address[IW-1:0];
  assign tag      = address[ADDR_W-1:IW];
  assign s_idx    = snoop_addr[IW-1:0];
  assign s_tag_in = snoop_addr[ADDR_W-1:IW];
  assign scmd     = bus_cmd_t'(snoop_cmd);
  assign miss_cmd = store_control ? BUS_RDX : BUS_RD;

  assign hit     = (c_state != I) && (c_tag == tag);
  assign s_match = snoop_valid && (s_state != I)
                && (s_tag == s_tag_in);

  l1_line_array #(.n(n), .LINES(LINES)) u_lines (
    .clk      (clk),
    .reset    (reset),
    .c_idx    (idx),
    .c_tag    (c_tag),
    .c_state  (c_state),
    .c_data   (c_data),
    .c_we     (c_we),
    .c_wtag   (c_wtag),
    .c_wstate (c_wstate),
    .c_wdata  (c_wdata),
    .s_idx    (s_idx),
    .s_tag    (s_tag),
    .s_state  (s_state),
    .s_data   (s_data),
    .s_we     (s_we),
    .s_wstate (s_wstate)
  );

  // Snoop response and line-state update for a matching line.
  always_comb begin
    s_we     = 1'b0;
    s_wstate = s_state;
    hit_m_c  = 1'b0;
    if (s_match) begin
      unique case (scmd)
        BUS_RD: begin
          if (s_state == M) begin
            hit_m_c  = 1'b1;
            s_we     = 1'b1;
            s_wstate = S;
          end
        end
        BUS_RDX: begin
          hit_m_c  = (s_state == M);
          s_we     = 1'b1;
          s_wstate = I;
        end
        BUS_UPGR: begin
          if (s_state == S) begin
            s_we     = 1'b1;
            s_wstate = I;
          end
        end
        BUS_WB: ;
      endcase
    end
  end

  // A snoop touching the core's index wins this cycle;
  // kill means the line being upgraded is being invalidated.
  assign conflict = s_we && (s_idx == idx);
  assign kill     = s_we && (s_wstate == I)
                 && (snoop_addr == address);

  assign snoop_hit_m = hit_m_c & ~reset;
  assign snoop_data  = snoop_hit_m ? s_data : '0;
  assign L1_busy     = busy_c & ~reset;
  assign dmem_rdata  = rdata_c;
  assign bus_req     = req_q;
  assign bus_cmd     = cmd_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wd_q;

  // FSM state and registered bus request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      cmd_q  <= BUS_RD;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      state  <= state_n;
      req_q  <= req_n;
      cmd_q  <= cmd_n;
      addr_q <= addr_n;
      wd_q   <= wd_n;
    end
  end

  // Next state, bus request and line updates.
  always_comb begin
    state_n  = state;
    req_n    = req_q;
    cmd_n    = cmd_q;
    addr_n   = addr_q;
    wd_n     = wd_q;
    busy_c   = 1'b0;
    rdata_c  = '0;
    c_we     = 1'b0;
    c_wtag   = tag;
    c_wstate = c_state;
    c_wdata  = c_data;
    unique case (state)
      IDLE: begin
        if (load_control || store_control) begin
          if (conflict) begin
            busy_c = 1'b1;
          end else if (hit && !store_control) begin
            rdata_c = c_data;
          end else if (hit && c_state == M) begin
            c_we     = 1'b1;
            c_wstate = M;
            c_wdata  = dmem_wdata;
          end else if (hit) begin
            busy_c  = 1'b1;
            state_n = UPGRADE;
            req_n   = 1'b1;
            cmd_n   = BUS_UPGR;
            addr_n  = address;
            wd_n    = '0;
          end else if (c_state == M) begin
            busy_c  = 1'b1;
            state_n = WRITEBACK;
            req_n   = 1'b1;
            cmd_n   = BUS_WB;
            addr_n  = {c_tag, idx};
            wd_n    = c_data;
          end else begin
            busy_c  = 1'b1;
            state_n = FETCH;
            req_n   = 1'b1;
            cmd_n   = miss_cmd;
            addr_n  = address;
            wd_n    = '0;
          end
        end
      end
      WRITEBACK: begin
        busy_c = 1'b1;
        if (bus_ack) begin
          req_n    = 1'b0;
          state_n  = FETCH;
          c_we     = 1'b1;
          c_wtag   = c_tag;
          c_wstate = I;
        end
      end
      FETCH: begin
        busy_c = 1'b1;
        if (!req_q) begin
          req_n  = 1'b1;
          cmd_n  = miss_cmd;
          addr_n = address;
          wd_n   = '0;
        end else if (bus_ack) begin
          req_n    = 1'b0;
          state_n  = IDLE;
          c_we     = 1'b1;
          c_wstate = store_control ? M : S;
          c_wdata  = bus_rdata;
        end
      end
      UPGRADE: begin
        busy_c = 1'b1;
        if (!hit || kill) begin
          req_n   = 1'b0;
          state_n = FETCH;
        end else if (bus_ack) begin
          req_n    = 1'b0;
          state_n  = IDLE;
          c_we     = 1'b1;
          c_wstate = M;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Scoreboard bench for l1_cache_ctrl: expected bus
// transactions and load data are queued, then checked.
module tb_l1_cache_ctrl;
  import l1_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_control, store_control;
  logic [9:0]  address;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        L1_busy;
  logic        bus_req, bus_ack;
  logic [1:0]  bus_cmd;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        snoop_valid;
  logic [1:0]  snoop_cmd;
  logic [9:0]  snoop_addr;
  logic        snoop_hit_m;
  logic [31:0] snoop_data;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [9:0]  addr;
    logic [31:0] wd;
  } bus_t;

  bus_t        bq[$];
  logic [31:0] rq[$];
  logic [31:0] mem [1024];
  bus_t        e;
  int          checks = 0;
  int          failures = 0;
  bit          ack_en = 1'b1;
  bit          seen = 1'b0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl #(.n(32), .LINES(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_control  (load_control),
    .store_control (store_control),
    .address       (address),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .L1_busy       (L1_busy),
    .bus_req       (bus_req),
    .bus_cmd       (bus_cmd),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .snoop_valid   (snoop_valid),
    .snoop_cmd     (snoop_cmd),
    .snoop_addr    (snoop_addr),
    .snoop_hit_m   (snoop_hit_m),
    .snoop_data    (snoop_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus responder: checks each new request against the
  // expected queue, acks after a short delay.
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_ack) begin
        bus_ack = 1'b0;
        seen    = 1'b0;
        chk("bus_req_drop", {31'b0, bus_req}, 32'd0);
      end else if (!bus_req) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        wcnt = 2;
        if (bq.size() == 0) begin
          chk("bus_unexpected", {22'b0, bus_addr}, 32'hffff_ffff);
        end else begin
          e = bq.pop_front();
          chk("bus_cmd", {30'b0, bus_cmd}, {30'b0, e.cmd});
          chk("bus_addr", {22'b0, bus_addr}, {22'b0, e.addr});
          chk("bus_wdata", bus_wdata, e.wd);
        end
      end else if (wcnt > 0) begin
        wcnt--;
      end else if (ack_en) begin
        bus_ack = 1'b1;
        if (bus_cmd == BUS_WB) mem[bus_addr] = bus_wdata;
        else bus_rdata = mem[bus_addr];
      end
    end
  end

  task automatic push_bus(input bus_cmd_t c,
                          input logic [9:0] a,
                          input logic [31:0] d);
    bus_t t;
    t.cmd  = c;
    t.addr = a;
    t.wd   = d;
    bq.push_back(t);
  endtask

  task automatic wait_free(input string tag);
    int k = 0;
    while (L1_busy && k < 60) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (L1_busy) chk(tag, 32'd1, 32'd0);
  endtask

  task automatic do_load(input logic [9:0] a,
                         input logic [31:0] d,
                         input bit stall);
    rq.push_back(d);
    @(posedge clk);
    #1;
    address      = a;
    load_control = 1'b1;
    #1;
    chk("ld_stall", {31'b0, L1_busy}, {31'b0, stall});
    wait_free("ld_timeout");
    chk("ld_data", dmem_rdata, rq.pop_front());
    @(posedge clk);
    #1;
    load_control = 1'b0;
  endtask

  task automatic do_store(input logic [9:0] a,
                          input logic [31:0] d,
                          input bit stall);
    @(posedge clk);
    #1;
    address       = a;
    dmem_wdata    = d;
    store_control = 1'b1;
    #1;
    chk("st_stall", {31'b0, L1_busy}, {31'b0, stall});
    wait_free("st_timeout");
    @(posedge clk);
    #1;
    store_control = 1'b0;
  endtask

  task automatic snp(input bus_cmd_t c,
                     input logic [9:0] a,
                     input bit hm,
                     input logic [31:0] sd);
    @(posedge clk);
    #1;
    snoop_valid = 1'b1;
    snoop_cmd   = c;
    snoop_addr  = a;
    #1;
    chk("snp_hit_m", {31'b0, snoop_hit_m}, {31'b0, hm});
    chk("snp_data", snoop_data, sd);
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    reset         = 1'b1;
    load_control  = 1'b0;
    store_control = 1'b0;
    address       = '0;
    dmem_wdata    = '0;
    snoop_valid   = 1'b0;
    snoop_cmd     = '0;
    snoop_addr    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, L1_busy}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_hit_m", {31'b0, snoop_hit_m}, 32'd0);
    chk("rst_snp_data", snoop_data, 32'd0);

    // cold load miss, then hit in S
    mem[10'h025] = 32'hDEADBEEF;
    push_bus(BUS_RD, 10'h025, 32'h0);
    do_load(10'h025, 32'hDEADBEEF, 1'b1);
    do_load(10'h025, 32'hDEADBEEF, 1'b0);

    // store to S upgrades, then zero-stall store hit in M
    push_bus(BUS_UPGR, 10'h025, 32'h0);
    do_store(10'h025, 32'h11, 1'b1);
    do_store(10'h025, 32'h22, 1'b0);
    do_load(10'h025, 32'h22, 1'b0);

    // conflict miss with dirty victim
    mem[10'h035] = 32'hCAFE0035;
    push_bus(BUS_WB, 10'h025, 32'h22);
    push_bus(BUS_RD, 10'h035, 32'h0);
    do_load(10'h035, 32'hCAFE0035, 1'b1);
    chk("wb_mem", mem[10'h025], 32'h22);

    // bring 0x025 back and make it M holding 0x22
    push_bus(BUS_RD, 10'h025, 32'h0);
    do_load(10'h025, 32'h22, 1'b1);
    push_bus(BUS_UPGR, 10'h025, 32'h0);
    do_store(10'h025, 32'h22, 1'b1);

    // snoops: RD on M supplies data, then S, RDX invalidates
    snp(BUS_RD, 10'h025, 1'b1, 32'h22);
    snp(BUS_RD, 10'h025, 1'b0, 32'h0);
    snp(BUS_RDX, 10'h025, 1'b0, 32'h0);
    push_bus(BUS_RD, 10'h025, 32'h0);
    do_load(10'h025, 32'h22, 1'b1);

    // RDX snoop kills the line mid-upgrade
    push_bus(BUS_UPGR, 10'h025, 32'h0);
    push_bus(BUS_RDX, 10'h025, 32'h0);
    ack_en = 1'b0;
    @(posedge clk);
    #1;
    address       = 10'h025;
    dmem_wdata    = 32'h55;
    store_control = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    snoop_valid = 1'b1;
    snoop_cmd   = BUS_RDX;
    snoop_addr  = 10'h025;
    #1;
    chk("upg_snp_hit_m", {31'b0, snoop_hit_m}, 32'd0);
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    ack_en      = 1'b1;
    wait_free("upg_timeout");
    @(posedge clk);
    #1;
    store_control = 1'b0;
    do_load(10'h025, 32'h55, 1'b0);

    // snoop and core hit the same index together
    @(posedge clk);
    #1;
    address      = 10'h025;
    load_control = 1'b1;
    snoop_valid  = 1'b1;
    snoop_cmd    = BUS_RD;
    snoop_addr   = 10'h025;
    #1;
    chk("cf_busy", {31'b0, L1_busy}, 32'd1);
    chk("cf_hit_m", {31'b0, snoop_hit_m}, 32'd1);
    chk("cf_snp_data", snoop_data, 32'h55);
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    #1;
    chk("cf_busy2", {31'b0, L1_busy}, 32'd0);
    chk("cf_rdata", dmem_rdata, 32'h55);
    load_control = 1'b0;

    // same index, other tag: no snoop effect
    snp(BUS_RDX, 10'h035, 1'b0, 32'h0);
    do_load(10'h025, 32'h55, 1'b0);

    // reset in the middle of a fetch
    mem[10'h077] = 32'h77777777;
    push_bus(BUS_RD, 10'h077, 32'h0);
    ack_en = 1'b0;
    @(posedge clk);
    #1;
    address      = 10'h077;
    load_control = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("fetch_req", {31'b0, bus_req}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rst2_req", {31'b0, bus_req}, 32'd0);
    chk("rst2_busy", {31'b0, L1_busy}, 32'd0);
    @(posedge clk);
    #1;
    load_control = 1'b0;
    reset        = 1'b0;
    ack_en       = 1'b1;
    push_bus(BUS_RD, 10'h077, 32'h0);
    do_load(10'h077, 32'h77777777, 1'b1);
    push_bus(BUS_RD, 10'h025, 32'h0);
    do_load(10'h025, 32'h22, 1'b1);

    repeat (4) @(posedge clk);
    chk("bus_q_empty", bq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
